// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO register-port arbiter: register offsets,
// master ids and arbiter state encoding.
package gpio_pkg;

    localparam logic [7:0] REG_OUT  = 8'h00;
    localparam logic [7:0] REG_MASK = 8'h04;
    localparam logic [7:0] REG_DIR  = 8'h08;
    localparam logic [7:0] REG_IN   = 8'h0C;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    localparam logic [1:0] FREE    = 2'd0;
    localparam logic [1:0] LOCKED0 = 2'd1;
    localparam logic [1:0] LOCKED1 = 2'd2;

endpackage

// File: rtl/gpio_rd_tag_pipe.sv
// Fixed-latency delay line carrying {valid, master id} for outstanding reads,
// so each response can be steered back to the master that issued it.
module gpio_rd_tag_pipe #(
    parameter int unsigned RD_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    input  logic in_id,
    output logic out_valid,
    output logic out_id
);

    logic [RD_LAT-1:0] vld_q;
    logic [RD_LAT-1:0] id_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            id_q  <= '0;
        end else begin
            vld_q[0] <= in_valid;
            id_q[0]  <= in_id;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                id_q[i]  <= id_q[i-1];
            end
        end
    end

    assign out_valid = vld_q[RD_LAT-1];
    assign out_id    = id_q[RD_LAT-1];

endmodule

// File: rtl/gpio_bus_arb.sv
// Two-master round-robin arbiter for the GPIO register port, with bus lock,
// lock-timeout watchdog and tag-routed read responses.
module gpio_bus_arb
    import gpio_pkg::*;
#(
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned LOCK_MAX = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic          m0_lock,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    input  logic          m1_lock,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr_o,
    output logic [DW-1:0] wr_data_o,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr_o,
    input  logic [DW-1:0] rd_data_i,
    output logic          lock_err
);

    localparam int unsigned CW = $clog2(LOCK_MAX + 1);

    logic [1:0]    state_q, state_d;
    logic          ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    ign_q, ign_d;
    logic          err_q, err_d;
    logic          g0, g1, lk0, lk1, prio, arb_free;

    always_comb begin
        g0       = 1'b0;
        g1       = 1'b0;
        arb_free = 1'b0;
        prio     = ptr_q;
        state_d  = state_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        err_d    = err_q;
        // A timed-out lock stays ignored until its master lets it drop once.
        ign_d    = ign_q & {m1_lock, m0_lock};
        lk0      = m0_lock & ~ign_q[0];
        lk1      = m1_lock & ~ign_q[1];

        case (state_q)
            LOCKED0: begin
                if (!m0_lock) begin
                    g0      = m0_req;
                    state_d = FREE;
                    cnt_d   = '0;
                end else if (cnt_q >= CW'(LOCK_MAX)) begin
                    arb_free = 1'b1;
                    prio     = M1;
                    ptr_d    = M1;
                    lk0      = 1'b0;
                    ign_d[0] = 1'b1;
                    err_d    = 1'b1;
                    state_d  = FREE;
                    cnt_d    = '0;
                end else begin
                    g0    = m0_req;
                    cnt_d = cnt_q + CW'(1);
                end
            end
            LOCKED1: begin
                if (!m1_lock) begin
                    g1      = m1_req;
                    state_d = FREE;
                    cnt_d   = '0;
                end else if (cnt_q >= CW'(LOCK_MAX)) begin
                    arb_free = 1'b1;
                    prio     = M0;
                    ptr_d    = M0;
                    lk1      = 1'b0;
                    ign_d[1] = 1'b1;
                    err_d    = 1'b1;
                    state_d  = FREE;
                    cnt_d    = '0;
                end else begin
                    g1    = m1_req;
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: arb_free = 1'b1;
        endcase

        if (arb_free) begin
            if (m0_req && (!m1_req || prio == M0)) begin
                g0 = 1'b1;
            end else if (m1_req) begin
                g1 = 1'b1;
            end
            if (g0 && lk0) begin
                state_d = LOCKED0;
                cnt_d   = CW'(1);
            end else if (g1 && lk1) begin
                state_d = LOCKED1;
                cnt_d   = CW'(1);
            end
        end

        if (g0) begin
            ptr_d = M1;
        end else if (g1) begin
            ptr_d = M0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FREE;
            ptr_q   <= M0;
            cnt_q   <= '0;
            ign_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            ign_q   <= ign_d;
            err_q   <= err_d;
        end
    end

    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          pipe_valid, pipe_id;

    assign sel_addr  = g1 ? m1_addr : m0_addr;
    assign sel_wdata = g1 ? m1_wdata : m0_wdata;

    assign m0_gnt    = g0;
    assign m1_gnt    = g1;
    assign wr_en     = (g0 & m0_we) | (g1 & m1_we);
    assign rd_en     = (g0 & ~m0_we) | (g1 & ~m1_we);
    assign wr_addr_o = wr_en ? sel_addr : '0;
    assign wr_data_o = wr_en ? sel_wdata : '0;
    assign rd_addr_o = rd_en ? sel_addr : '0;
    assign lock_err  = err_q;

    gpio_rd_tag_pipe #(
        .RD_LAT(RD_LAT)
    ) u_rd_tag_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (rd_en),
        .in_id    (g1),
        .out_valid(pipe_valid),
        .out_id   (pipe_id)
    );

    assign m0_rvalid = pipe_valid & (pipe_id == M0);
    assign m1_rvalid = pipe_valid & (pipe_id == M1);
    assign m0_rdata  = m0_rvalid ? rd_data_i : '0;
    assign m1_rdata  = m1_rvalid ? rd_data_i : '0;

endmodule

// File: tb/tb_gpio_bus_arb.sv
// Directed bench for gpio_bus_arb: three instances share stimulus and differ
// only in RD_LAT (index g has RD_LAT = g + 1), all with LOCK_MAX = 8.
module tb_gpio_bus_arb;
    import gpio_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m0_req = 1'b0, m1_req = 1'b0, m0_we = 1'b0, m1_we = 1'b0;
    logic        m0_lock = 1'b0, m1_lock = 1'b0;
    logic [31:0] m0_addr = '0, m1_addr = '0, m0_wdata = '0, m1_wdata = '0;
    logic [31:0] rd_data;
    int unsigned cyc = 0;

    logic        o_m0_gnt [3], o_m1_gnt [3], o_m0_rvalid [3], o_m1_rvalid [3];
    logic [31:0] o_m0_rdata [3], o_m1_rdata [3];
    logic        o_wr_en [3], o_rd_en [3], o_lock_err [3];
    logic [31:0] o_wr_addr [3], o_wr_data [3], o_rd_addr [3];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign rd_data = 32'hA5A5_0000 + cyc;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        gpio_bus_arb #(
            .AW(32), .DW(32), .RD_LAT(g + 1), .LOCK_MAX(8)
        ) u_dut (
            .clk(clk), .rst_n(rst_n),
            .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
            .m0_lock(m0_lock), .m0_gnt(o_m0_gnt[g]), .m0_rvalid(o_m0_rvalid[g]),
            .m0_rdata(o_m0_rdata[g]),
            .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
            .m1_lock(m1_lock), .m1_gnt(o_m1_gnt[g]), .m1_rvalid(o_m1_rvalid[g]),
            .m1_rdata(o_m1_rdata[g]),
            .wr_en(o_wr_en[g]), .wr_addr_o(o_wr_addr[g]), .wr_data_o(o_wr_data[g]),
            .rd_en(o_rd_en[g]), .rd_addr_o(o_rd_addr[g]), .rd_data_i(rd_data),
            .lock_err(o_lock_err[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    // Timeout scenario, bit i = cycle i+1 after the first grant.
    logic [14:0] exp_g0  = 15'b110_1010_1111_1111;
    logic [14:0] lk0_pat = 15'b111_0111_1111_1111;
    int unsigned iss [4];

    initial begin
        // Reset values
        tick();
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            check("rst_m0_gnt", 32'(o_m0_gnt[g]), 32'd0);
            check("rst_wr_en", 32'(o_wr_en[g]), 32'd0);
            check("rst_rd_en", 32'(o_rd_en[g]), 32'd0);
            check("rst_lock_err", 32'(o_lock_err[g]), 32'd0);
            check("rst_m1_rvalid", 32'(o_m1_rvalid[g]), 32'd0);
        end
        tick();
        rst_n = 1'b1;

        // Single write from m0, m1 idle
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'(REG_MASK); m0_wdata = 32'h0000_00FF;
        @(negedge clk);
        check("wr_m0_gnt", 32'(o_m0_gnt[0]), 32'd1);
        check("wr_m1_gnt", 32'(o_m1_gnt[0]), 32'd0);
        check("wr_en", 32'(o_wr_en[0]), 32'd1);
        check("wr_rd_en", 32'(o_rd_en[0]), 32'd0);
        check("wr_addr", o_wr_addr[0], 32'h04);
        check("wr_data", o_wr_data[0], 32'hFF);
        tick();
        m0_req = 1'b0;

        // Round-robin reads from reset, RD_LAT = 1
        reset_dut();
        m0_req = 1'b1; m1_req = 1'b1; m0_we = 1'b0; m1_we = 1'b0;
        m0_addr = 32'(REG_IN); m1_addr = 32'(REG_IN);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k < 4) begin
                check("rr_m0_gnt", 32'(o_m0_gnt[0]), (k % 2 == 0) ? 32'd1 : 32'd0);
                check("rr_m1_gnt", 32'(o_m1_gnt[0]), (k % 2 == 1) ? 32'd1 : 32'd0);
                check("rr_rd_en", 32'(o_rd_en[0]), 32'd1);
                check("rr_rd_addr", o_rd_addr[0], 32'h0C);
                iss[k] = cyc;
            end
            if (k == 0) begin
                check("rr_m0_rvalid0", 32'(o_m0_rvalid[0]), 32'd0);
                check("rr_m1_rvalid0", 32'(o_m1_rvalid[0]), 32'd0);
            end else begin
                check("rr_m0_rvalid", 32'(o_m0_rvalid[0]), ((k - 1) % 2 == 0) ? 32'd1 : 32'd0);
                check("rr_m1_rvalid", 32'(o_m1_rvalid[0]), ((k - 1) % 2 == 1) ? 32'd1 : 32'd0);
                if ((k - 1) % 2 == 0)
                    check("rr_m0_rdata", o_m0_rdata[0], 32'hA5A5_0000 + iss[k-1] + 1);
                else
                    check("rr_m1_rdata", o_m1_rdata[0], 32'hA5A5_0000 + iss[k-1] + 1);
            end
            tick();
            if (k == 3) begin
                m0_req = 1'b0; m1_req = 1'b0;
            end
        end

        // m1 locked mask-then-value sequence, m0 must not interleave
        m1_req = 1'b1; m1_we = 1'b1; m1_lock = 1'b1;
        m1_addr = 32'(REG_MASK); m1_wdata = 32'h0F;
        @(negedge clk);
        check("lk_a_m1_gnt", 32'(o_m1_gnt[0]), 32'd1);
        check("lk_a_wr_addr", o_wr_addr[0], 32'h04);
        tick();
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'(REG_OUT); m0_wdata = 32'h11;
        m1_addr = 32'(REG_OUT); m1_wdata = 32'h22;
        @(negedge clk);
        check("lk_b_m0_gnt", 32'(o_m0_gnt[0]), 32'd0);
        check("lk_b_m1_gnt", 32'(o_m1_gnt[0]), 32'd1);
        check("lk_b_wr_data", o_wr_data[0], 32'h22);
        tick();
        m1_req = 1'b0; m1_lock = 1'b0;
        @(negedge clk);
        check("lk_c_m0_gnt", 32'(o_m0_gnt[0]), 32'd0);
        check("lk_c_wr_en", 32'(o_wr_en[0]), 32'd0);
        tick();
        @(negedge clk);
        check("lk_d_m0_gnt", 32'(o_m0_gnt[0]), 32'd1);
        check("lk_d_wr_data", o_wr_data[0], 32'h11);
        tick();
        m0_req = 1'b0;

        // Lock timeout at LOCK_MAX = 8
        reset_dut();
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'(REG_DIR); m0_wdata = 32'h3;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'(REG_OUT); m1_wdata = 32'h5;
        for (int i = 0; i < 15; i++) begin
            m0_lock = lk0_pat[i];
            @(negedge clk);
            check($sformatf("to_m0_gnt_c%0d", i + 1), 32'(o_m0_gnt[0]), 32'(exp_g0[i]));
            check($sformatf("to_m1_gnt_c%0d", i + 1), 32'(o_m1_gnt[0]), 32'(!exp_g0[i]));
            check($sformatf("to_lock_err_c%0d", i + 1), 32'(o_lock_err[0]),
                  (i >= 9) ? 32'd1 : 32'd0);
            tick();
        end
        m0_req = 1'b0; m1_req = 1'b0; m0_lock = 1'b0;

        // Three back-to-back m0 reads, RD_LAT = 3
        reset_dut();
        m0_we = 1'b0; m0_addr = 32'(REG_IN);
        for (int k = 0; k < 8; k++) begin
            m0_req = (k < 3);
            @(negedge clk);
            if (k < 3) begin
                iss[k] = cyc;
                check("l3_rd_en", 32'(o_rd_en[2]), 32'd1);
            end
            check("l3_m0_rvalid", 32'(o_m0_rvalid[2]), (k >= 3 && k <= 5) ? 32'd1 : 32'd0);
            check("l3_m1_rvalid", 32'(o_m1_rvalid[2]), 32'd0);
            if (k >= 3 && k <= 5)
                check("l3_m0_rdata", o_m0_rdata[2], 32'hA5A5_0000 + iss[k-3] + 3);
            tick();
        end

        // Reset one cycle after an m1 read grant, RD_LAT = 2
        reset_dut();
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'(REG_IN);
        @(negedge clk);
        check("mr_m1_gnt", 32'(o_m1_gnt[1]), 32'd1);
        tick();
        m1_req = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check("mr_rvalid_in_rst", 32'(o_m1_rvalid[1]), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("mr_m1_rvalid", 32'(o_m1_rvalid[1]), 32'd0);
            check("mr_rd_en", 32'(o_rd_en[1]), 32'd0);
            check("mr_lock_err", 32'(o_lock_err[1]), 32'd0);
            tick();
        end
        m0_req = 1'b1; m1_req = 1'b1; m0_we = 1'b0;
        @(negedge clk);
        check("mr_post_m0_gnt", 32'(o_m0_gnt[1]), 32'd1);
        check("mr_post_m1_gnt", 32'(o_m1_gnt[1]), 32'd0);
        tick();
        m0_req = 1'b0; m1_req = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
